// File: rtl/section_razor_ctrl.sv
// Frame sequencer for a chain of razor-protected decoder sections.
// Issues symbols, flushes the pipeline, and recovers from razor errors by stall-and-replay.
module section_razor_ctrl #(
  parameter int unsigned NSEC      = 8,
  parameter int unsigned L_W       = 10,
  parameter int unsigned STALL_CYC = 2,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             start,
  input  logic [L_W-1:0]   frame_len,
  input  logic [NSEC-1:0]  Error_in,
  output logic             advance,
  output logic             sym_valid,
  output logic [L_W-1:0]   sym_idx,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag
);

  localparam int unsigned F_W = $clog2(NSEC + 1);
  localparam int unsigned S_W = $clog2(STALL_CYC + 1);

  localparam logic [F_W-1:0]   FCNT_LAST = F_W'(NSEC - 1);
  localparam logic [F_W-1:0]   F_ONE     = F_W'(1);
  localparam logic [S_W-1:0]   SCNT_INIT = S_W'(STALL_CYC - 1);
  localparam logic [S_W-1:0]   S_ONE     = S_W'(1);
  localparam logic [L_W-1:0]   L_ONE     = L_W'(1);
  localparam logic [ERR_W-1:0] E_ONE     = ERR_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  state_t           ret_state, ret_state_nxt;
  logic [L_W-1:0]   len_q, len_nxt;
  logic [L_W-1:0]   sym_idx_nxt;
  logic [F_W-1:0]   fcnt, fcnt_nxt;
  logic [S_W-1:0]   scnt, scnt_nxt;
  logic [ERR_W-1:0] err_count_nxt;
  logic             err_flag_nxt;
  logic             err;

  assign err = |Error_in;

  // Outputs are pure decodes of the registered state: no path from Error_in.
  assign advance   = (state == RUN) || (state == FLUSH);
  assign sym_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      ret_state <= RUN;
      len_q     <= '0;
      sym_idx   <= '0;
      fcnt      <= '0;
      scnt      <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      len_q     <= len_nxt;
      sym_idx   <= sym_idx_nxt;
      fcnt      <= fcnt_nxt;
      scnt      <= scnt_nxt;
      err_count <= err_count_nxt;
      err_flag  <= err_flag_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    len_nxt       = len_q;
    sym_idx_nxt   = sym_idx;
    fcnt_nxt      = fcnt;
    scnt_nxt      = scnt;
    err_count_nxt = err_count;
    err_flag_nxt  = err_flag;

    unique case (state)
      IDLE: begin
        if (start) begin
          len_nxt       = frame_len;
          sym_idx_nxt   = '0;
          err_count_nxt = '0;
          err_flag_nxt  = 1'b0;
          state_nxt     = (frame_len == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        if (err) begin
          state_nxt     = STALL;
          ret_state_nxt = RUN;
          scnt_nxt      = SCNT_INIT;
        end else begin
          sym_idx_nxt = sym_idx + L_ONE;
          if (sym_idx_nxt == len_q) begin
            state_nxt = FLUSH;
            fcnt_nxt  = '0;
          end
        end
      end

      STALL: begin
        if (scnt == '0) begin
          state_nxt = ret_state;
        end else begin
          scnt_nxt = scnt - S_ONE;
        end
      end

      FLUSH: begin
        if (err) begin
          state_nxt     = STALL;
          ret_state_nxt = FLUSH;
          scnt_nxt      = SCNT_INIT;
        end else if (fcnt == FCNT_LAST) begin
          state_nxt = DONE;
        end else begin
          fcnt_nxt = fcnt + F_ONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Errors only count while the sections are actually clocked.
    if (advance && err) begin
      err_flag_nxt = 1'b1;
      if (err_count != '1) begin
        err_count_nxt = err_count + E_ONE;
      end
    end
  end

endmodule

// File: tb/tb_section_razor_ctrl.sv
// Bench for section_razor_ctrl: issue-slot model compared every cycle,
// plus literal done-cycle, issued-sequence and error-count expectations per frame.
module tb_section_razor_ctrl;

  localparam int unsigned NSEC      = 8;
  localparam int unsigned L_W       = 10;
  localparam int unsigned STALL_CYC = 2;
  localparam int unsigned ERR_W     = 2;

  logic             Clock = 1'b0;
  logic             nReset = 1'b1;
  logic             start = 1'b0;
  logic [L_W-1:0]   frame_len = '0;
  logic [NSEC-1:0]  Error_in = '0;
  logic             advance;
  logic             sym_valid;
  logic [L_W-1:0]   sym_idx;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_count;
  logic             err_flag;

  section_razor_ctrl #(
    .NSEC(NSEC),
    .L_W(L_W),
    .STALL_CYC(STALL_CYC),
    .ERR_W(ERR_W)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .start(start),
    .frame_len(frame_len),
    .Error_in(Error_in),
    .advance(advance),
    .sym_valid(sym_valid),
    .sym_idx(sym_idx),
    .busy(busy),
    .done(done),
    .err_count(err_count),
    .err_flag(err_flag)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is len symbol slots followed by NSEC flush slots.
  // phase 0 idle, 1 issuing/stalling, 2 done pulse.
  int m_phase = 0;
  int m_len   = 0;
  int m_pos   = 0;
  int m_stall = 0;
  int m_ec    = 0;
  int m_ef    = 0;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_phase <= 0; m_len <= 0; m_pos <= 0; m_stall <= 0; m_ec <= 0; m_ef <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_len   <= int'(frame_len);
          m_pos   <= 0;
          m_stall <= 0;
          m_ec    <= 0;
          m_ef    <= 0;
          m_phase <= (frame_len == '0) ? 2 : 1;
        end
        1: begin
          if (m_stall > 0) begin
            m_stall <= m_stall - 1;
          end else if (Error_in != '0) begin
            m_stall <= STALL_CYC;
            m_ef    <= 1;
            m_ec    <= (m_ec < (1 << ERR_W) - 1) ? m_ec + 1 : m_ec;
          end else begin
            m_pos <= m_pos + 1;
            if (m_pos + 1 == m_len + int'(NSEC)) m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge Clock) begin
    automatic int e_adv = (m_phase == 1 && m_stall == 0) ? 1 : 0;
    automatic int e_sv  = (e_adv == 1 && m_pos < m_len) ? 1 : 0;
    automatic int e_idx = (m_pos < m_len) ? m_pos : m_len;
    check("advance",   32'(advance),   32'(e_adv));
    check("sym_valid", 32'(sym_valid), 32'(e_sv));
    check("sym_idx",   32'(sym_idx),   32'(e_idx));
    check("busy",      32'(busy),      32'(m_phase != 0));
    check("done",      32'(done),      32'(m_phase == 2));
    check("err_count", 32'(err_count), 32'(m_ec));
    check("err_flag",  32'(err_flag),  32'(m_ef));
  end

  int issued[$];
  int adv_cnt;
  int done_cyc;

  // Runs one frame. Errors: pattern p1 in cycle e1, all-ones in cycle e2,
  // all-ones in every cycle lo..hi. hold keeps start high (and changes frame_len) while busy.
  task automatic run_frame(input int len, input int e1, input logic [NSEC-1:0] p1,
                           input int e2, input int lo, input int hi, input bit hold);
    issued.delete();
    adv_cnt  = 0;
    done_cyc = -1;
    @(posedge Clock); #2;
    start = 1'b1; frame_len = L_W'(len); Error_in = '0;
    @(posedge Clock); #2;
    if (hold) frame_len = L_W'(len + 4);
    else start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      Error_in = (k == e1) ? p1 : (k == e2) ? '1 : (k >= lo && k <= hi) ? '1 : '0;
      @(negedge Clock);
      if (sym_valid) issued.push_back(int'(sym_idx));
      if (advance) adv_cnt++;
      if (done) begin
        done_cyc = k;
        start = 1'b0;
        Error_in = '0;
        break;
      end
      @(posedge Clock); #2;
    end
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_len"}, 32'(issued.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < issued.size(); i++)
      check(name, 32'(issued[i]), 32'(exp[i]));
  endtask

  initial begin
    #1 nReset = 1'b0;
    #1;
    check("rst_advance", 32'(advance), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_sym_idx", 32'(sym_idx), 32'd0);
    check("rst_err_cnt", 32'(err_count), 32'd0);
    repeat (2) @(posedge Clock);
    #2 nReset = 1'b1;

    // T1: clean frame
    run_frame(4, 0, '0, 0, 0, -1, 1'b0);
    check("t1_done_cyc", 32'(done_cyc), 32'd13);
    check("t1_adv_cnt",  32'(adv_cnt),  32'd12);
    check("t1_err_cnt",  32'(err_count), 32'd0);
    check_seq("t1_seq", '{0, 1, 2, 3});

    // T2: single error in cycle 2
    run_frame(4, 2, 8'h01, 0, 0, -1, 1'b0);
    check("t2_done_cyc", 32'(done_cyc), 32'd16);
    check("t2_err_cnt",  32'(err_count), 32'd1);
    check("t2_err_flag", 32'(err_flag),  32'd1);
    check_seq("t2_seq", '{0, 1, 1, 2, 3});

    // T3: error on last symbol and on last flush cycle
    run_frame(3, 3, 8'h80, 14, 0, -1, 1'b0);
    check("t3_done_cyc", 32'(done_cyc), 32'd18);
    check("t3_err_cnt",  32'(err_count), 32'd2);
    check_seq("t3_seq", '{0, 1, 2, 2});

    // T4: continuous errors for 30 cycles -> 10 counted, saturates at 3
    run_frame(2, 0, '0, 0, 1, 30, 1'b0);
    check("t4_done_cyc", 32'(done_cyc), 32'd41);
    check("t4_err_cnt",  32'(err_count), 32'd3);
    check("t4_err_flag", 32'(err_flag),  32'd1);

    // T5: empty frame, then a frame with start held high while busy
    run_frame(0, 0, '0, 0, 0, -1, 1'b0);
    check("t5_done_cyc", 32'(done_cyc), 32'd1);
    check("t5_adv_cnt",  32'(adv_cnt),  32'd0);
    check("t5_err_clr",  32'(err_count), 32'd0);
    run_frame(3, 0, '0, 0, 0, -1, 1'b1);
    check("t5b_done_cyc", 32'(done_cyc), 32'd12);
    check_seq("t5b_seq", '{0, 1, 2});

    // T6: asynchronous reset while sym_idx=5 with one error already counted
    @(posedge Clock); #2;
    start = 1'b1; frame_len = L_W'(10);
    @(posedge Clock); #2;
    start = 1'b0;
    done_cyc = -1;
    for (int k = 1; k <= 50; k++) begin
      Error_in = (k == 2) ? 8'h04 : '0;
      @(negedge Clock);
      if (sym_valid && sym_idx == L_W'(5)) begin
        done_cyc = k;
        break;
      end
      @(posedge Clock); #2;
    end
    check("t6_reach_idx5", 32'(done_cyc), 32'd9);
    check("t6_err_before", 32'(err_count), 32'd1);
    #1 nReset = 1'b0;
    #1;
    check("t6_rst_advance", 32'(advance),   32'd0);
    check("t6_rst_valid",   32'(sym_valid), 32'd0);
    check("t6_rst_idx",     32'(sym_idx),   32'd0);
    check("t6_rst_busy",    32'(busy),      32'd0);
    check("t6_rst_done",    32'(done),      32'd0);
    check("t6_rst_errcnt",  32'(err_count), 32'd0);
    check("t6_rst_errflag", 32'(err_flag),  32'd0);
    @(posedge Clock); #2 nReset = 1'b1;
    run_frame(2, 0, '0, 0, 0, -1, 1'b0);
    check("t6_done_cyc", 32'(done_cyc), 32'd11);
    check_seq("t6_seq", '{0, 1});

    repeat (3) @(posedge Clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
